// File: rtl/ad9516_spi_pkg.sv
// Shared constants and FSM encoding for the AD9516 SPI register read engine.
package ad9516_spi_pkg;

   localparam int unsigned ADDR_W   = 13;
   localparam int unsigned INSTR_W  = 16;
   localparam int unsigned DATA_W   = 8;
   localparam int unsigned NUM_BITS = INSTR_W + DATA_W;

   localparam logic       RW_READ = 1'b1;
   localparam logic [1:0] W_1BYTE = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP,
      ST_DONE
   } state_t;

   function automatic logic [INSTR_W-1:0] read_instr(input logic [ADDR_W-1:0] addr);
      return {RW_READ, W_1BYTE, addr};
   endfunction

endpackage

// File: rtl/ad9516_spi_tick.sv
// SCLK half-period divider: drives sclk and strobes the first high cycle and last high cycle.
module ad9516_spi_tick #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   output logic sclk_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt;
   logic          phase;
   logic          half_end;

   assign half_end = (cnt == CW'(CLK_DIV - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i || !en_i) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (half_end) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // rise_o marks the cycle sclk first reads high; fall_o the last high cycle.
   assign sclk_o = phase;
   assign rise_o = en_i && phase && (cnt == '0);
   assign fall_o = en_i && phase && half_end;

endmodule

// File: rtl/ad9516_spi_reader.sv
// Single-byte AD9516 register read: 16-bit read instruction on SDIO, 8 data bits captured from SDO.
module ad9516_spi_reader
   import ad9516_spi_pkg::*;
#(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned CS_SETUP = 4,
   parameter int unsigned CS_HOLD  = 4
) (
   input  logic              sys_clk_i,
   input  logic              rst_i,
   input  logic              rd_start_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              rd_done_o,
   output logic              busy_o,
   output logic              cs_o,
   output logic              sclk_o,
   output logic              sdio_o,
   input  logic              sdo_i
);

   localparam int unsigned TMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int unsigned TW   = $clog2(TMAX + 1);

   state_t              state, state_d;
   logic [TW-1:0]       timer;
   logic [4:0]          bit_cnt;
   logic [INSTR_W-1:0]  shift_out;
   logic [DATA_W-1:0]   shift_in;
   logic                accept;
   logic                sclk_rise;
   logic                sclk_fall;
   logic                last_bit;

   assign accept   = rd_start_i && (state == ST_IDLE || state == ST_DONE);
   assign last_bit = (bit_cnt == 5'(NUM_BITS - 1));
   assign sdio_o   = shift_out[INSTR_W-1];

   ad9516_spi_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk_i  (sys_clk_i),
      .rst_i  (rst_i),
      .en_i   (state == ST_SHIFT),
      .sclk_o (sclk_o),
      .rise_o (sclk_rise),
      .fall_o (sclk_fall)
   );

   always_ff @(posedge sys_clk_i) begin
      if (rst_i) state <= ST_IDLE;
      else       state <= state_d;
   end

   always_comb begin
      state_d = state;
      unique case (state)
         ST_IDLE,
         ST_DONE:  state_d = accept ? ST_SETUP : ST_IDLE;
         ST_SETUP: if (timer == TW'(CS_SETUP - 1)) state_d = ST_SHIFT;
         ST_SHIFT: if (sclk_fall && last_bit)      state_d = ST_HOLD;
         ST_HOLD:  if (timer == TW'(CS_HOLD - 1))  state_d = ST_GAP;
         ST_GAP:   if (timer == TW'(CS_HOLD - 1))  state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Interface outputs are registered from state_d so they change exactly with the state.
   always_ff @(posedge sys_clk_i) begin
      if (rst_i) begin
         timer     <= '0;
         bit_cnt   <= '0;
         shift_out <= '0;
         shift_in  <= '0;
         rd_data_o <= '0;
         rd_done_o <= 1'b0;
         busy_o    <= 1'b0;
         cs_o      <= 1'b1;
      end else begin
         if (state_d == state &&
             (state == ST_SETUP || state == ST_HOLD || state == ST_GAP))
            timer <= timer + 1'b1;
         else
            timer <= '0;

         if (accept) begin
            shift_out <= read_instr(rd_addr_i);
            bit_cnt   <= '0;
         end else if (sclk_fall) begin
            shift_out <= {shift_out[INSTR_W-2:0], 1'b0};
            bit_cnt   <= bit_cnt + 1'b1;
         end

         if (sclk_rise)
            shift_in <= {shift_in[DATA_W-2:0], sdo_i};

         if (state_d == ST_DONE && state != ST_DONE)
            rd_data_o <= shift_in;

         rd_done_o <= (state_d == ST_DONE);
         busy_o    <= (state_d inside {ST_SETUP, ST_SHIFT, ST_HOLD, ST_GAP});
         cs_o      <= !(state_d inside {ST_SETUP, ST_SHIFT, ST_HOLD});
      end
   end

endmodule
